// File: rtl/agc_pkg.sv
// Shared definitions for the AGC loop controller: FSM state encoding and
// width helpers for the log value and the signed loop error.
package agc_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCUM  = 3'd1;
    localparam logic [2:0] ST_LOG    = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_SETTLE = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        ACCUM  = ST_ACCUM,
        LOG    = ST_LOG,
        UPDATE = ST_UPDATE,
        SETTLE = ST_SETTLE
    } agc_state_t;

    // Integer part holds the leading-one position of a DATA_WIDTH+1 bit value.
    function automatic int log_width(input int data_width, input int frac_bits);
        return $clog2(data_width + 1) + frac_bits;
    endfunction

    // One extra bit so target - measured never overflows.
    function automatic int err_width(input int data_width, input int frac_bits);
        return log_width(data_width, frac_bits) + 1;
    endfunction

endpackage

// File: rtl/leading_one_detector.sv
// Position of the most significant set bit; found=0 when the input is zero.
module leading_one_detector #(
    parameter int WIDTH = 13,
    parameter int PW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    output logic [PW-1:0]    pos,
    output logic             found
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        pos   = '0;
        found = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            if (din[b]) begin
                pos   = PW'(b);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mitchell_log2.sv
// Combinational Mitchell log2: {leading-one position, truncated mantissa bits}.
// A zero input maps to zero.
module mitchell_log2
    import agc_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int FRAC_BITS  = 4,
    localparam int LW        = log_width(DATA_WIDTH, FRAC_BITS)
) (
    input  logic [DATA_WIDTH:0] avg,
    output logic [LW-1:0]       log_val
);

    localparam int KW = LW - FRAC_BITS;

    logic [KW-1:0]        k;
    logic                 found;
    logic [KW-1:0]        shamt;
    logic [FRAC_BITS-1:0] frac;

    leading_one_detector #(.WIDTH(DATA_WIDTH + 1), .PW(KW)) u_lod (
        .din   (avg),
        .pos   (k),
        .found (found)
    );

    // Normalise the leading one to bit DATA_WIDTH, then keep the bits just below it.
    assign shamt   = KW'(DATA_WIDTH) - k;
    assign frac    = FRAC_BITS'((avg << shamt) >> (DATA_WIDTH - FRAC_BITS));
    assign log_val = found ? {k, frac} : '0;

endmodule

// File: rtl/agc_loop_controller.sv
// Closed-loop AGC sequencer: window |I|+|Q| accumulation, Mitchell log2 of the
// window average, deadband compare against target_log, gain step, settle hold-off.
// Optional build macro AGC_FAST_ATTACK_EN: a full-scale sample aborts the window
// and immediately backs the gain off by COARSE_STEP.
module agc_loop_controller
    import agc_pkg::*;
#(
    parameter int DATA_WIDTH    = 12,
    parameter int WIN_LOG2      = 4,
    parameter int FRAC_BITS     = 4,
    parameter int GAIN_WIDTH    = 6,
    parameter int INIT_GAIN     = 32,
    parameter int HYST          = 2,
    parameter int COARSE_STEP   = 4,
    parameter int SETTLE_CYCLES = 8,
    localparam int LW           = log_width(DATA_WIDTH, FRAC_BITS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         sample_valid,
    input  logic signed [DATA_WIDTH-1:0] i_in,
    input  logic signed [DATA_WIDTH-1:0] q_in,
    input  logic [LW-1:0]                target_log,
    output logic [GAIN_WIDTH-1:0]        gain_idx,
    output logic                         gain_update,
    output logic                         locked,
    output logic [LW-1:0]                log_pwr
);

    localparam int AW   = DATA_WIDTH + 1 + WIN_LOG2;
    localparam int EW   = err_width(DATA_WIDTH, FRAC_BITS);
    localparam int SW   = $clog2(SETTLE_CYCLES) + 1;
    localparam int GMAX = (1 << GAIN_WIDTH) - 1;

    agc_state_t              state, state_nxt;
    logic [AW-1:0]           acc;
    logic [WIN_LOG2-1:0]     cnt;
    logic [SW-1:0]           settle_cnt;
    logic [DATA_WIDTH:0]     mag_i, mag_q;
    logic [LW-1:0]           log_val;
    logic signed [EW-1:0]    err;
    logic [EW-1:0]           aerr;
    int                      step, g_int;
    logic [GAIN_WIDTH-1:0]   gain_sat, gain_nxt;
    logic                    upd_nxt, locked_nxt;
    logic [LW-1:0]           log_nxt;

    // |x| in one extra bit so the most negative code is exact.
    function automatic logic [DATA_WIDTH:0] mag(input logic signed [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH:0] xe;
        xe = {x[DATA_WIDTH-1], x};
        return x[DATA_WIDTH-1] ? -xe : xe;
    endfunction

    assign mag_i = mag(i_in);
    assign mag_q = mag(q_in);

    mitchell_log2 #(.DATA_WIDTH(DATA_WIDTH), .FRAC_BITS(FRAC_BITS)) u_log (
        .avg     (acc[AW-1:WIN_LOG2]),
        .log_val (log_val)
    );

    assign err  = $signed({1'b0, target_log}) - $signed({1'b0, log_pwr});
    assign aerr = err[EW-1] ? $unsigned(-err) : $unsigned(err);

    // Candidate gain after one loop step, clamped to the index range.
    always_comb begin
        step  = (int'(aerr) >= (1 << FRAC_BITS)) ? COARSE_STEP : 1;
        g_int = err[EW-1] ? int'(gain_idx) - step : int'(gain_idx) + step;
        if (g_int < 0)
            g_int = 0;
        else if (g_int > GMAX)
            g_int = GMAX;
        gain_sat = GAIN_WIDTH'(g_int);
    end

`ifdef AGC_FAST_ATTACK_EN
    localparam logic signed [DATA_WIDTH-1:0] FS_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] FS_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic                  clip;
    logic [GAIN_WIDTH-1:0] gain_fa;
    assign clip    = (i_in == FS_POS) || (i_in == FS_NEG) || (q_in == FS_POS) || (q_in == FS_NEG);
    assign gain_fa = (int'(gain_idx) > COARSE_STEP) ? gain_idx - GAIN_WIDTH'(COARSE_STEP) : '0;
`endif

    // Next state and next values of the loop outputs; en=0 overrides everything.
    always_comb begin
        state_nxt  = state;
        gain_nxt   = gain_idx;
        upd_nxt    = 1'b0;
        locked_nxt = locked;
        log_nxt    = log_pwr;
        if (!en) begin
            state_nxt  = IDLE;
            locked_nxt = 1'b0;
        end else begin
            case (state)
                IDLE:   state_nxt = ACCUM;
                ACCUM: begin
`ifdef AGC_FAST_ATTACK_EN
                    if (sample_valid && clip) begin
                        gain_nxt   = gain_fa;
                        upd_nxt    = (gain_fa != gain_idx);
                        locked_nxt = 1'b0;
                        state_nxt  = SETTLE;
                    end else
`endif
                    if (sample_valid && cnt == '1)
                        state_nxt = LOG;
                end
                LOG: begin
                    log_nxt   = log_val;
                    state_nxt = UPDATE;
                end
                UPDATE: begin
                    if (int'(aerr) <= HYST) begin
                        locked_nxt = 1'b1;
                        state_nxt  = ACCUM;
                    end else begin
                        locked_nxt = 1'b0;
                        gain_nxt   = gain_sat;
                        upd_nxt    = (gain_sat != gain_idx);
                        state_nxt  = (gain_sat != gain_idx) ? SETTLE : ACCUM;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SW'(SETTLE_CYCLES - 1))
                        state_nxt = ACCUM;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Window accumulator and counters; anything outside ACCUM clears the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            settle_cnt <= '0;
        end else begin
            if (state == ACCUM) begin
                if (sample_valid) begin
                    acc <= acc + AW'(mag_i) + AW'(mag_q);
                    cnt <= cnt + WIN_LOG2'(1);
                end
            end else begin
                acc <= '0;
                cnt <= '0;
            end
            settle_cnt <= (state == SETTLE) ? settle_cnt + SW'(1) : '0;
        end
    end

    // Registered loop outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gain_idx    <= GAIN_WIDTH'(INIT_GAIN);
            gain_update <= 1'b0;
            locked      <= 1'b0;
            log_pwr     <= '0;
        end else begin
            gain_idx    <= gain_nxt;
            gain_update <= upd_nxt;
            locked      <= locked_nxt;
            log_pwr     <= log_nxt;
        end
    end

endmodule

// File: doc/agc_loop_controller.md
# agc_loop_controller

Closed-loop automatic gain control sequencer for the AGC front end. It accumulates |I|+|Q| magnitude over a fixed window of samples, converts the window average to a Mitchell log2 value through a shared log datapath built on the leading-one detector, and compares the result against a programmable target. It then steps a gain index and holds off for an analog settling period before measuring again. The block sits between the baseband sample stream and the RF/VGA gain register.

## Interface
- DATA_WIDTH, 12: signed I/Q sample width.
- WIN_LOG2, 4: measurement window is 2^WIN_LOG2 accepted samples.
- FRAC_BITS, 4: fractional bits of the log value. Must satisfy FRAC_BITS <= DATA_WIDTH.
- GAIN_WIDTH, 6: gain index width.
- INIT_GAIN, 32: gain index reset value.
- HYST, 2: lock deadband, in log LSBs.
- COARSE_STEP, 4: gain step applied when |err| >= 2^FRAC_BITS.
- SETTLE_CYCLES, 8: hold-off clocks after each gain change.
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  loop enable.
- sample_valid  in  1  i_in/q_in valid this cycle.
- i_in, q_in  in  DATA_WIDTH  signed samples.
- target_log  in  LW  target log2 power, unsigned. LW = clog2(DATA_WIDTH+1)+FRAC_BITS (8 at defaults).
- gain_idx  out  GAIN_WIDTH  current gain index.
- gain_update  out  1  one-cycle pulse when gain_idx changes.
- locked  out  1  last measurement fell within the deadband.
- log_pwr  out  LW  last measured log2 power.

## Operation
- States: IDLE, ACCUM, LOG, UPDATE, SETTLE.
- IDLE → ACCUM when en=1. Entry clears the accumulator and sample counter.
- ACCUM:
  - On sample_valid, add |i_in|+|q_in| (DATA_WIDTH+1 bits; |−2^(DATA_WIDTH−1)| = 2^(DATA_WIDTH−1), exact) into an accumulator of DATA_WIDTH+1+WIN_LOG2 bits.
  - After 2^WIN_LOG2 accepted samples, → LOG.
- LOG:
  - avg = acc >> WIN_LOG2.
  - k = leading-one position of avg.
  - frac = bits directly below the MSB, taken as the top FRAC_BITS of (avg << (DATA_WIDTH−k)), truncated.
  - log_pwr <= {k, frac}. If avg = 0, log_pwr <= 0.
  - → UPDATE.
- UPDATE:
  - err = target_log − log_pwr, signed LW+1 bits.
  - If |err| <= HYST: locked <= 1, gain unchanged, → ACCUM.
  - Otherwise: gain moves toward sign(err) by COARSE_STEP if |err| >= 2^FRAC_BITS, else by 1. The result saturates to [0, 2^GAIN_WIDTH−1]; locked <= 0.
  - If the saturated gain differs from the current gain: gain_update pulses, → SETTLE. If saturation left it unchanged: no pulse, → ACCUM.
- SETTLE: counts SETTLE_CYCLES clocks, ignoring samples, then → ACCUM with the accumulator cleared.
- Samples presented outside ACCUM are discarded and not counted.
- en=0 in any state: → IDLE at the next edge. The partial window is discarded, gain_idx and log_pwr are held, and locked is cleared.
- target_log is sampled only in UPDATE. It may change at any time.

## Timing
- Reset values: gain_idx=INIT_GAIN, gain_update=0, locked=0, log_pwr=0; state=IDLE, accumulator=0, counters=0.
- Reset mid-window aborts immediately; no partial update occurs.
- Latency: final sample accepted at edge E → log_pwr valid after E+1 → gain_idx/gain_update valid after E+2 (same cycle).
- Minimum loop period per gain change: 2^WIN_LOG2 samples + 2 + SETTLE_CYCLES clocks.
- gain_update is never high two consecutive cycles.

## Configuration
- AGC_FAST_ATTACK_EN defined:
  - In ACCUM, a sample with i_in or q_in equal to either full-scale code (2^(DATA_WIDTH−1)−1 or −2^(DATA_WIDTH−1)) aborts the window.
  - The abort decrements gain by COARSE_STEP (saturating at 0), pulses gain_update if gain_idx changed, clears locked, and goes to SETTLE on the next edge.
  - LOG/UPDATE are skipped and log_pwr is held.
- Undefined: clipped samples are accumulated like any other.

## Structure
- Package agc_pkg holds:
  - the state encoding localparams;
  - the LW width function;
  - the signed error width.
- Sub-module mitchell_log2: combinational, DATA_WIDTH+1 input → LW output. It instantiates the existing leading_one_detector plus the normalising shifter. The controller registers its output in LOG.

## Test plan
Default parameters, target_log=128 (8.0) unless stated.
1. 16 samples I=256, Q=0 → log_pwr=128, locked=1, gain_idx stays 32, no gain_update.
2. 16 samples I=1024, Q=0 → log_pwr=160, err=−32 → gain_idx=28, one gain_update pulse two edges after the last sample, then 8 settle clocks ignoring samples.
3. 16 samples I=300 → log_pwr=130 (frac truncated to 2), err=−2 → locked=1, no change. I=200 → log_pwr=121, err=+7 → gain_idx 32→33.
4. Force gain_idx=63 with a small signal (I=Q=1) → gain_idx stays 63, no gain_update, locked=0.
5. en dropped after 10 samples, re-raised → next measurement requires 16 fresh samples. Asserting rst mid-SETTLE restores gain_idx=32.
6. With AGC_FAST_ATTACK_EN, third sample I=−2048 → gain_idx 32→28 on the next edge, SETTLE entered, log_pwr unchanged. Without the macro, the window completes normally.
